// File: rtl/ctrl_link_pkg.sv
// Shared control-link constants: frame header/terminator bytes, opcodes, TX FSM encoding.
// CMD_FRAME_TX_TERM_EN selects whether the 0x0D terminator byte is appended.
package ctrl_link_pkg;

  localparam logic [7:0] HDR0 = 8'h7E;
  localparam logic [7:0] HDR1 = 8'h30;
  localparam logic [7:0] HDR2 = 8'h5F;
  localparam logic [7:0] TERM = 8'h0D;

  localparam logic [7:0] OP_FM    = 8'h66;  // 'f'
  localparam logic [7:0] OP_AM    = 8'h61;  // 'a'
  localparam logic [7:0] OP_ADR   = 8'h7A;  // 'z'
  localparam logic [7:0] OP_WR    = 8'h77;  // 'w'
  localparam logic [7:0] OP_SCLK  = 8'h63;  // 'c'
  localparam logic [7:0] OP_RD    = 8'h72;  // 'r'
  localparam logic [7:0] OP_REGIM = 8'h67;  // 'g'
  localparam logic [7:0] OP_TST   = 8'h69;  // 'i'
  localparam logic [7:0] OP_SW    = 8'h73;  // 's'

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_BYTE  = 3'd2;
  localparam logic [2:0] ST_SEND  = 3'd3;
  localparam logic [2:0] ST_GUARD = 3'd4;
  localparam logic [2:0] ST_WAIT  = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

`ifdef CMD_FRAME_TX_TERM_EN
  localparam logic [3:0] LAST_IDX = 4'd9;
`else
  localparam logic [3:0] LAST_IDX = 4'd8;
`endif

  typedef struct packed {
    logic [7:0]  code;
    logic [31:0] data;
  } cmd_t;

  function automatic logic op_legal(input logic [7:0] op);
    logic ok;
    case (op)
      OP_FM, OP_AM, OP_ADR, OP_WR, OP_SCLK,
      OP_RD, OP_REGIM, OP_TST, OP_SW: ok = 1'b1;
      default:                        ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [7:0] sum5(input logic [7:0] code, input logic [31:0] data);
    return code + data[31:24] + data[23:16] + data[15:8] + data[7:0];
  endfunction

endpackage

// File: rtl/ctrl_link_crc8.sv
// Registered 8-bit additive checksum of opcode plus four argument bytes (carry dropped).
// Result updates one cycle after en; holds otherwise.
module ctrl_link_crc8
  import ctrl_link_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [7:0]  code,
  input  logic [31:0] data,
  output logic [7:0]  crc
);

  logic [7:0] crc_d, crc_q;

  always_comb begin
    crc_d = crc_q;
    if (en) crc_d = sum5(code, data);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) crc_q <= 8'h00;
    else        crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/cmd_frame_tx.sv
// Serialises one accepted command into a 9-byte frame (10 with CMD_FRAME_TX_TERM_EN) for the UART TX core.
// First send 3 cycles after accept; 3+GUARD_CYC cycles per byte; stalls without limit while uart_busy.
module cmd_frame_tx
  import ctrl_link_pkg::*;
#(
  parameter int GUARD_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_code,
  input  logic [31:0] cmd_data,
  output logic [7:0]  tx_data,
  output logic        send,
  input  logic        uart_busy,
  output logic        frame_done,
  output logic        cmd_err
);

  localparam logic [3:0] GUARD_LAST = 4'(GUARD_CYC - 1);

  logic [2:0] state_d, state_q;
  logic [3:0] idx_d, idx_q;
  logic [3:0] guard_d, guard_q;
  cmd_t       cmd_d, cmd_q;
  logic [7:0] tx_data_d, tx_data_q;
  logic       send_d, send_q;
  logic       frame_done_d, frame_done_q;
  logic       cmd_err_d, cmd_err_q;
  logic       cmd_ready_d, cmd_ready_q;
  logic       crc_en;
  logic [7:0] crc;
  logic [7:0] cur_byte;
  logic       accept;

  ctrl_link_crc8 u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (crc_en),
    .code  (cmd_q.code),
    .data  (cmd_q.data),
    .crc   (crc)
  );

  assign accept = cmd_valid & cmd_ready_q & (state_q == ST_IDLE);

  always_comb begin
    cur_byte = 8'h00;
    case (idx_q)
      4'd0: cur_byte = HDR0;
      4'd1: cur_byte = HDR1;
      4'd2: cur_byte = HDR2;
      4'd3: cur_byte = cmd_q.code;
      4'd4: cur_byte = cmd_q.data[31:24];
      4'd5: cur_byte = cmd_q.data[23:16];
      4'd6: cur_byte = cmd_q.data[15:8];
      4'd7: cur_byte = cmd_q.data[7:0];
      4'd8: cur_byte = crc;
`ifdef CMD_FRAME_TX_TERM_EN
      4'd9: cur_byte = TERM;
`endif
      default: cur_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    guard_d   = guard_q;
    cmd_d     = cmd_q;
    tx_data_d = tx_data_q;
    crc_en    = 1'b0;
    cmd_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (op_legal(cmd_code)) begin
            cmd_d   = '{code: cmd_code, data: cmd_data};
            idx_d   = 4'd0;
            state_d = ST_LOAD;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        crc_en  = 1'b1;
        state_d = ST_BYTE;
      end
      ST_BYTE: begin
        if (!uart_busy) begin
          tx_data_d = cur_byte;
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        guard_d = 4'd0;
        state_d = ST_GUARD;
      end
      ST_GUARD: begin
        // uart_busy may lag the send strobe, so it is not looked at here
        if (guard_q == GUARD_LAST) state_d = ST_WAIT;
        else                       guard_d = guard_q + 4'd1;
      end
      ST_WAIT: begin
        if (!uart_busy) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = ST_BYTE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    send_d       = (state_d == ST_SEND);
    frame_done_d = (state_d == ST_DONE);
    // ready drops for the cmd_err cycle so a held bad command is not re-rejected back to back
    cmd_ready_d  = (state_d == ST_IDLE) && !cmd_err_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= 4'd0;
      guard_q      <= 4'd0;
      cmd_q        <= '0;
      tx_data_q    <= 8'h00;
      send_q       <= 1'b0;
      frame_done_q <= 1'b0;
      cmd_err_q    <= 1'b0;
      cmd_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      guard_q      <= guard_d;
      cmd_q        <= cmd_d;
      tx_data_q    <= tx_data_d;
      send_q       <= send_d;
      frame_done_q <= frame_done_d;
      cmd_err_q    <= cmd_err_d;
      cmd_ready_q  <= cmd_ready_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign tx_data    = tx_data_q;
  assign send       = send_q;
  assign frame_done = frame_done_q;
  assign cmd_err    = cmd_err_q;

endmodule
